// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W  = 32;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_TIMEOUT = 255;
  localparam int unsigned ARB_PERF_W  = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_D = 2'd1;
  localparam logic [1:0] ST_BUSY_I = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_D = ST_BUSY_D,
    BUSY_I = ST_BUSY_I,
    RESP   = ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } arb_owner_t;

  // Wait counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating event counters for the arbiter: data completions, fetch completions, stall cycles.
module mem_arb_perf
  import mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = ARB_PERF_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_inc_i,
  input  logic             i_inc_i,
  input  logic             stall_inc_i,
  output logic [CNT_W-1:0] perf_d_cnt_o,
  output logic [CNT_W-1:0] perf_i_cnt_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o
);

  logic [2:0]       inc;
  logic [CNT_W-1:0] cnt_all [3];

  assign inc = {stall_inc_i, i_inc_i, d_inc_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (inc[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
  end

  assign perf_d_cnt_o     = cnt_all[0];
  assign perf_i_cnt_o     = cnt_all[1];
  assign perf_stall_cnt_o = cnt_all[2];

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch and data streams, with ack timeout.
// Performance counters are compiled in only when MEM_ARB_PERF_EN is defined; otherwise they read 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       perf_d_cnt,
  output logic [31:0]       perf_i_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam int unsigned      CNT_W      = wait_cnt_w(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  arb_owner_t        owner;
  logic              timed_out;
  logic [DATA_W-1:0] resp_data;

  assign owner     = (state_q == BUSY_I) ? OWN_I : OWN_D;
  assign timed_out = TIMEOUT_EN && (wait_q == WAIT_LAST);
  // A real ack beats a timeout landing on the same edge.
  assign resp_data = mem_ack ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    wait_d      = wait_q;

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          wait_d      = '0;
        end else if (i_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          wait_d     = '0;
        end
      end

      BUSY_D, BUSY_I: begin
        if (mem_ack || timed_out) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = ~mem_ack;
          if (owner == OWN_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = resp_data;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign stall     = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf #(
    .CNT_W(32)
  ) u_perf (
    .clk_i           (CLK),
    .rst_i           (RESET),
    .d_inc_i         (d_ack_q),
    .i_inc_i         (i_ack_q),
    .stall_inc_i     (stall),
    .perf_d_cnt_o    (perf_d_cnt),
    .perf_i_cnt_o    (perf_i_cnt),
    .perf_stall_cnt_o(perf_stall_cnt)
  );
`else
  assign perf_d_cnt     = '0;
  assign perf_i_cnt     = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, store, timeout, reset abort, perf counters.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic [31:0] perf_d_cnt;
  logic [31:0] perf_i_cnt;
  logic [31:0] perf_stall_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Memory responder: acks after ack_lat extra BUSY cycles while enabled.
  logic        ack_en = 1'b0;
  logic        force_ack = 1'b0;
  int unsigned ack_lat = 0;
  int unsigned mcnt = 0;
  int unsigned stall_cycles = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    mcnt <= mem_req ? mcnt + 1 : 0;
  end

  assign mem_ack = force_ack | (ack_en & mem_req & (mcnt == ack_lat));

  always @(posedge CLK) begin
    if (RESET) stall_cycles <= 0;
    else if (stall) stall_cycles <= stall_cycles + 1;
  end

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_rdata       (i_rdata),
    .i_ack         (i_ack),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_ack         (d_ack),
    .err           (err),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .perf_d_cnt    (perf_d_cnt),
    .perf_i_cnt    (perf_i_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_xfer(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    int  cyc;
    bit  done;
    cyc       = 0;
    done      = 1'b0;
    mem_rdata = rdata;
    ack_en    = 1'b1;
    ack_lat   = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      done = is_d ? d_ack : i_ack;
    end
    if (is_d) begin
      check_val("xfer_d_ack", {31'd0, done}, 32'd1);
      if (!we) check_val("xfer_d_rdata", d_rdata, rdata);
    end else begin
      check_val("xfer_i_ack", {31'd0, done}, 32'd1);
      check_val("xfer_i_rdata", i_rdata, rdata);
    end
    d_req = 1'b0;
    i_req = 1'b0;
    $display("xfer %s we=%0d addr=0x%08h rdata=0x%08h cycles=%0d", is_d ? "D" : "I", we, addr, rdata, cyc);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_i_ack", {31'd0, i_ack}, 32'd0);
    check_val("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_i_rdata", i_rdata, 32'd0);
    check_val("rst_d_rdata", d_rdata, 32'd0);
    check_val("rst_perf_i", perf_i_cnt, 32'd0);
    check_val("rst_perf_d", perf_d_cnt, 32'd0);
    check_val("rst_perf_stall", perf_stall_cnt, 32'd0);
    RESET = 1'b0;
    tick();

    // Minimum-latency fetch
    ack_en = 1'b1; ack_lat = 0; mem_rdata = 32'h00A00093;
    i_req = 1'b1; i_addr = 32'h40;
    #1;
    check_val("fetch_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    check_val("fetch_mem_req_c1", {31'd0, mem_req}, 32'd1);
    check_val("fetch_mem_addr_c1", mem_addr, 32'h40);
    check_val("fetch_mem_we_c1", {31'd0, mem_we}, 32'd0);
    check_val("fetch_i_ack_c1", {31'd0, i_ack}, 32'd0);
    tick();
    check_val("fetch_i_ack_c2", {31'd0, i_ack}, 32'd1);
    check_val("fetch_i_rdata_c2", i_rdata, 32'h00A00093);
    check_val("fetch_mem_req_c2", {31'd0, mem_req}, 32'd0);
    check_val("fetch_err_c2", {31'd0, err}, 32'd0);
    i_req = 1'b0;
    tick();
    check_val("fetch_stall_c3", {31'd0, stall}, 32'd0);
    check_val("fetch_i_ack_c3", {31'd0, i_ack}, 32'd0);
    $display("fetch addr=0x40 done");

    // Collision: data wins, fetch follows three cycles after d_ack
    mem_rdata = 32'h11111111;
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    check_val("coll_mem_addr_d", mem_addr, 32'h100);
    check_val("coll_mem_req_d", {31'd0, mem_req}, 32'd1);
    tick();
    check_val("coll_d_ack", {31'd0, d_ack}, 32'd1);
    check_val("coll_i_ack_early", {31'd0, i_ack}, 32'd0);
    check_val("coll_d_rdata", d_rdata, 32'h11111111);
    d_req = 1'b0;
    mem_rdata = 32'h22222222;
    #1;
    check_val("coll_stall_i_wait", {31'd0, stall}, 32'd1);
    tick();
    check_val("coll_idle_i_ack", {31'd0, i_ack}, 32'd0);
    check_val("coll_idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    check_val("coll_mem_addr_i", mem_addr, 32'h44);
    tick();
    check_val("coll_i_ack", {31'd0, i_ack}, 32'd1);
    check_val("coll_i_rdata", i_rdata, 32'h22222222);
    check_val("coll_d_rdata_hold", d_rdata, 32'h11111111);
    i_req = 1'b0;
    tick();
    $display("collision load=0x100 fetch=0x44 done");

    // Store leaves d_rdata untouched
    mem_rdata = 32'h33333333;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    tick();
    check_val("st_mem_we", {31'd0, mem_we}, 32'd1);
    check_val("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check_val("st_mem_addr", mem_addr, 32'h200);
    tick();
    check_val("st_d_ack", {31'd0, d_ack}, 32'd1);
    check_val("st_d_rdata_hold", d_rdata, 32'h11111111);
    check_val("st_err", {31'd0, err}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_val("st_mem_we_after", {31'd0, mem_we}, 32'd0);
    $display("store addr=0x200 data=0xdeadbeef done");

    // mem_ack while idle is ignored
    force_ack = 1'b1;
    tick();
    tick();
    check_val("ign_d_ack", {31'd0, d_ack}, 32'd0);
    check_val("ign_i_ack", {31'd0, i_ack}, 32'd0);
    check_val("ign_mem_req", {31'd0, mem_req}, 32'd0);
    force_ack = 1'b0;
    $display("stray mem_ack in idle done");

    // Timeout: memory never answers
    ack_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("to_mem_req", {31'd0, mem_req}, 32'd1);
      check_val("to_d_ack_wait", {31'd0, d_ack}, 32'd0);
    end
    tick();
    check_val("to_d_ack", {31'd0, d_ack}, 32'd1);
    check_val("to_err", {31'd0, err}, 32'd1);
    check_val("to_d_rdata", d_rdata, 32'd0);
    check_val("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    d_req = 1'b0;
    tick();
    check_val("to_err_clear", {31'd0, err}, 32'd0);
    $display("timeout load=0x300 done");

    // Ack on the last wait cycle wins over the timeout
    ack_en = 1'b1; ack_lat = 3; mem_rdata = 32'h44444444;
    d_req = 1'b1; d_addr = 32'h304;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    tick();
    check_val("late_d_ack", {31'd0, d_ack}, 32'd1);
    check_val("late_err", {31'd0, err}, 32'd0);
    check_val("late_d_rdata", d_rdata, 32'h44444444);
    d_req = 1'b0;
    tick();
    $display("late ack load=0x304 done");

    // Reset in BUSY_I abandons the fetch
    ack_en = 1'b0; ack_lat = 0;
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    check_val("rb_mem_req_busy", {31'd0, mem_req}, 32'd1);
    RESET = 1'b1;
    tick();
    check_val("rb_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rb_i_ack", {31'd0, i_ack}, 32'd0);
    check_val("rb_err", {31'd0, err}, 32'd0);
    RESET = 1'b0;
    ack_en = 1'b1; mem_rdata = 32'h55555555;
    tick();
    check_val("rb_refetch_addr", mem_addr, 32'h80);
    tick();
    check_val("rb_refetch_ack", {31'd0, i_ack}, 32'd1);
    check_val("rb_refetch_rdata", i_rdata, 32'h55555555);
    i_req = 1'b0;
    tick();
    $display("reset abort + refetch addr=0x80 done");

    // Perf counters: one fetch already since reset, plus two fetches and two loads
    do_xfer(1'b0, 1'b0, 32'h90, 32'h0, 32'h66666666);
    tick();
    do_xfer(1'b1, 1'b0, 32'h400, 32'h0, 32'h77777777);
    tick();
    do_xfer(1'b0, 1'b0, 32'h94, 32'h0, 32'h88888888);
    tick();
    do_xfer(1'b1, 1'b0, 32'h404, 32'h0, 32'h99999999);
    tick();
`ifdef MEM_ARB_PERF_EN
    check_val("perf_i", perf_i_cnt, 32'd3);
    check_val("perf_d", perf_d_cnt, 32'd2);
    check_val("perf_stall", perf_stall_cnt, stall_cycles);
    check_val("perf_stall_nonzero", {31'd0, (perf_stall_cnt != 0)}, 32'd1);
`else
    check_val("perf_i", perf_i_cnt, 32'd0);
    check_val("perf_d", perf_d_cnt, 32'd0);
    check_val("perf_stall", perf_stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
